// File: rtl/multi_debouncer.sv
// multi_debouncer
// Multi-channel level debouncer for pushbuttons and switches. Each channel
// filters its raw level into a clean level and emits registered one-cycle
// rise/fall pulses, so downstream FSMs need no edge detectors of their own.
// MODE=0 debounces both edges. MODE=1 debounces the press and applies the
// release immediately.
// Optional macro DEBOUNCE_SYNC_EN inserts a two-flop synchroniser (reset to 0)
// on every raw input. This adds 2 cycles to every latency.
module multi_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int MODE          = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_edge
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] TERM_CNT = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CHANNELS-1:0] s;
  logic [CW-1:0]       cnt     [CHANNELS];
  logic [CW-1:0]       cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] clean_nxt;
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;
  logic                any_edge_nxt;

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync_q1;
  logic [CHANNELS-1:0] sync_q2;

  // Two-flop synchroniser: pins may be asynchronous to clk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = raw;
`endif

  // Per-channel filter: any sample equal to clean restarts the count.
  // A full run of differing samples commits the new level.
  always_comb begin
    clean_nxt = clean;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = '0;
      if (s[i] != clean[i]) begin
        if ((MODE == 1) && !s[i]) begin
          // The legacy release applies at once, with no filtering
          clean_nxt[i] = 1'b0;
          fall_nxt[i]  = 1'b1;
        end else if (cnt[i] == TERM_CNT) begin
          clean_nxt[i] = s[i];
          rise_nxt[i]  = s[i];
          fall_nxt[i]  = ~s[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
    any_edge_nxt = |(rise_nxt | fall_nxt);
  end

  // State and output registers. Reset discards any partial count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clean    <= '0;
      rise     <= '0;
      fall     <= '0;
      any_edge <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      clean    <= clean_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
      any_edge <= any_edge_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule
